ifetch_queue: RTL and testbench
===============================

// Module: ifetch_queue
// PURPOSE
//  Instruction-fetch producer feeding the decode stage and its control ROM. Owns the fetch PC and
//  issues word reads to the instruction memory/cache port (one outstanding). Buffers returned
//  {pc, instr} pairs in a small FIFO and presents them to decode with a valid/ready handshake.
//  Accepts a redirect (flush) from branch/jump resolution and drops any stale in-flight response.
// PARAMETERS
//  DEPTH    4             FIFO entries; power of two, >= 2
//  RESET_PC 32'h00000060  fetch PC after reset
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst          in   1   asynchronous, active-high reset
//  imem_read    out  1   read request; held high until imem_resp
//  imem_address out  32  word address; bits[1:0]=0, stable while imem_read high
//  imem_resp    in   1   one-cycle response strobe
//  imem_rdata   in   32  instruction word, valid with imem_resp
//  flush        in   1   redirect strobe
//  flush_pc     in   32  new fetch PC; bits[1:0] forced to 0
//  out_valid    out  1   head entry valid
//  out_ready    in   1   decode accepts head entry
//  out_pc       out  32  PC of head entry
//  out_instr    out  32  instruction of head entry
// BEHAVIOUR
//  Reset (async): FIFO empty, out_valid=0, out_pc=0, out_instr=0, imem_read=0,
//   imem_address=RESET_PC, fetch_pc=RESET_PC, state=IDLE.
//  FSM states: IDLE, REQ, DISCARD.
//   IDLE: no read. Go to REQ when count<DEPTH and no flush this cycle.
//   REQ: imem_read=1, imem_address=fetch_pc.
//    - On imem_resp with no flush: push {fetch_pc, imem_rdata} and set fetch_pc+=4.
//      Stay in REQ if post-push count<DEPTH, else go to IDLE.
//    - On flush without imem_resp: go to DISCARD. Address stays stable; fetch_pc<=flush_pc.
//    - On flush with imem_resp in the same cycle: drop the data and go to REQ at flush_pc.
//   DISCARD: imem_read=1, imem_address is the old address. On imem_resp: drop the data and go to REQ.
//    A further flush while in DISCARD only updates fetch_pc.
//  FIFO:
//   - out_* are driven from the head entry. A pop occurs when out_valid & out_ready.
//   - When full, a push and a pop in the same cycle are both allowed (count unchanged).
//   - When empty, no bypass: the earliest out_valid is 1 cycle after imem_resp.
//   - Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
//  Flush has priority over everything. At the flush edge, the FIFO is emptied and the pop is
//   ignored, so out_valid=0 next cycle.
//  Latency: imem_resp -> out_valid is 1 cycle. Flush -> new request is 1 cycle (REQ),
//   or 1 cycle after the stale response (DISCARD).
//  Reset mid-request: imem_read drops immediately and combinationally with rst.
//   The memory side must tolerate an abandoned request.
//  fetch_pc+4 wraps modulo 2^32.
// CONFIGURATION
//  IFETCH_QUEUE_STATS_EN defined:
//   - Adds outputs stat_fetches, stat_flushes and stat_discards, each 32 bits. All reset to 0.
//   - They increment on push, on flush, and on a dropped response respectively.
//   - Each counter saturates at 32'hFFFFFFFF.
//  Not defined: the ports and logic are absent and the behaviour is otherwise identical.
// STRUCTURE
//  rv32i_types: add typedef struct packed {rv32i_word pc; rv32i_word instr;} ifq_entry_t
//   and localparam ifq_nop = 32'h00000013.
//  Sub-module ifq_fifo #(DEPTH): push, pop, clear, data_in/data_out (ifq_entry_t), full, empty, count.
//   It uses the same clk and async rst.
//  The FSM and fetch PC live in ifetch_queue.
// TESTING
//  1. Reset release, memory responds next cycle -> first imem_address=0x60.
//     out_pc=0x60 then 0x64, 0x68, ...; out_instr matches memory.
//  2. out_ready=0, memory always responding -> exactly 4 pushes, then imem_read=0 (IDLE).
//     Raise out_ready -> PCs 0x60..0x6C are drained in order and fetch resumes at 0x70.
//  3. Flush to 0x200 while in REQ and imem_resp=0 -> address stays until resp, data is dropped.
//     Next request is 0x200 and the first out_pc is 0x200.
//  4. Flush with imem_resp in the same cycle -> response dropped, FIFO empty next cycle,
//     next imem_address=0x200.
//  5. FIFO full, out_ready=1, imem_resp=1 in the same cycle -> count stays 4 and ordering is kept.
//  6. rst asserted mid-REQ -> imem_read=0 and out_valid=0 immediately.
//     After release, fetch restarts at 0x60.

Source files
------------

// File: rtl/ifetch_queue_pkg.sv
// ============================================================================
// ifetch_queue_pkg : shared types for the instruction-fetch queue
// Rev 1.0
// ============================================================================
`default_nettype none

package ifetch_queue_pkg;

    typedef logic [31:0] rv32i_word;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } ifq_entry_t;

    localparam rv32i_word ifq_nop = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } ifq_state_t;

    function automatic rv32i_word sat_inc(input rv32i_word v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_queue_fifo.sv
// ============================================================================
// ifq_fifo : {pc, instr} buffer with clear; full push+pop allowed together
// Rev 1.0
// ============================================================================
`default_nettype none

module ifq_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  ifq_entry_t               data_in,
    output ifq_entry_t               data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    ifq_entry_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full     = (r_count == C_FULL);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign data_out = r_mem[r_rd_ptr];

    assign w_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_in;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifetch_queue.sv
// ============================================================================
// ifetch_queue : fetch PC owner, single-outstanding imem reader, decode FIFO
// Optional counters: define IFETCH_QUEUE_STATS_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
`ifdef IFETCH_QUEUE_STATS_EN
    ,
    output logic [31:0] stat_fetches,
    output logic [31:0] stat_flushes,
    output logic [31:0] stat_discards
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    ifq_state_t  r_state, w_state_n;
    rv32i_word   r_fetch_pc, w_fetch_pc_n;
    rv32i_word   r_addr, w_addr_n;
    rv32i_word   w_flush_pc;
    logic        w_push, w_drop, w_pop;
    logic        w_full, w_empty;
    logic [AW:0] w_count, w_post_cnt;
    ifq_entry_t  w_head;

    assign w_flush_pc = flush_pc & ~32'h3;
    assign w_pop      = out_valid & out_ready & ~flush;
    assign w_post_cnt = w_count + (AW+1)'(1) - (AW+1)'(w_pop);

    assign imem_read    = (r_state != IDLE) & ~rst;
    assign imem_address = r_addr;
    assign out_valid    = ~w_empty;
    assign out_pc       = w_head.pc;
    assign out_instr    = w_head.instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
        end else begin
            r_state    <= w_state_n;
            r_fetch_pc <= w_fetch_pc_n;
            r_addr     <= w_addr_n;
        end
    end

    // r_addr tracks r_fetch_pc except while a flushed request is still outstanding.
    always_comb begin
        w_state_n    = r_state;
        w_fetch_pc_n = r_fetch_pc;
        w_addr_n     = r_addr;
        w_push       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (flush) begin
                    w_fetch_pc_n = w_flush_pc;
                    w_addr_n     = w_flush_pc;
                end else if (!w_full) begin
                    w_state_n = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    w_fetch_pc_n = w_flush_pc;
                    if (imem_resp) begin
                        w_drop   = 1'b1;
                        w_addr_n = w_flush_pc;
                    end else begin
                        w_state_n = DISCARD;
                    end
                end else if (imem_resp) begin
                    w_push       = 1'b1;
                    w_fetch_pc_n = r_fetch_pc + 32'd4;
                    w_addr_n     = r_fetch_pc + 32'd4;
                    w_state_n    = (w_post_cnt < C_FULL) ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (flush) begin
                    w_fetch_pc_n = w_flush_pc;
                end
                if (imem_resp) begin
                    w_drop    = 1'b1;
                    w_addr_n  = flush ? w_flush_pc : r_fetch_pc;
                    w_state_n = REQ;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .pop      (w_pop),
        .clear    (flush),
        .data_in  ('{pc: r_fetch_pc, instr: imem_rdata}),
        .data_out (w_head),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count)
    );

`ifdef IFETCH_QUEUE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_fetches  <= '0;
            stat_flushes  <= '0;
            stat_discards <= '0;
        end else begin
            if (w_push) stat_fetches  <= sat_inc(stat_fetches);
            if (flush)  stat_flushes  <= sat_inc(stat_flushes);
            if (w_drop) stat_discards <= sat_inc(stat_discards);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifetch_queue.sv
// ============================================================================
// tb_ifetch_queue : scoreboard + vector-table bench for ifetch_queue
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        flush;
    logic [31:0] flush_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    always #5 clk = ~clk;

    ifetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0060)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] fpc;
        bit          with_resp;
        int          pre;
        logic [31:0] exp_first;
    } fvec_t;

    exp_t        q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    bit          rdy, mem_en, flush_req, discard;
    logic [31:0] flush_tgt, exp_pc, exp_addr, old_addr;
    fvec_t       fv[4];

    function automatic logic [31:0] mk_instr(input logic [31:0] a);
        return a ^ 32'hA5C3_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    // One clock: drive inputs at the falling edge, check the handshake, update the model.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        flush     = flush_req;
        flush_pc  = flush_tgt;
        flush_req = 1'b0;
        out_ready = rdy;
        imem_resp = mem_en && imem_read;
        imem_rdata = imem_resp ? mk_instr(imem_address) : 32'h0;
        if (imem_resp && !discard) check("resp_addr", imem_address, exp_addr);
        if (out_valid && out_ready && !flush) begin
            if (q.size() == 0) begin
                check("unexpected_pop", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("pop_pc", out_pc, e.pc);
                check("pop_instr", out_instr, e.instr);
            end
        end
        if (flush) begin
            q.delete();
            exp_pc = flush_pc & ~32'h3;
            if (imem_resp || !imem_read) begin
                exp_addr = exp_pc;
                discard  = 1'b0;
            end else begin
                discard = 1'b1;
            end
        end else if (imem_resp) begin
            if (discard) begin
                discard  = 1'b0;
                exp_addr = exp_pc;
            end else begin
                q.push_back('{pc: exp_addr, instr: mk_instr(exp_addr)});
                exp_pc   = exp_pc + 32'd4;
                exp_addr = exp_pc;
            end
        end
    endtask

    task automatic wait_valid(input string name, input logic [31:0] first_pc);
        for (int k = 0; k < 20; k++) begin
            if (out_valid) break;
            cycle();
        end
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, "_pc"}, out_pc, first_pc);
    endtask

    initial begin
        fv[0] = '{fpc: 32'h0000_0200, with_resp: 1'b0, pre: 3, exp_first: 32'h0000_0200};
        fv[1] = '{fpc: 32'h0000_0200, with_resp: 1'b1, pre: 2, exp_first: 32'h0000_0200};
        fv[2] = '{fpc: 32'h0000_1003, with_resp: 1'b0, pre: 4, exp_first: 32'h0000_1000};
        fv[3] = '{fpc: 32'hFFFF_FFFC, with_resp: 1'b1, pre: 3, exp_first: 32'hFFFF_FFFC};

        rst = 1'b1; imem_resp = 1'b0; imem_rdata = '0; flush = 1'b0; flush_pc = '0;
        out_ready = 1'b0; rdy = 1'b0; mem_en = 1'b0; flush_req = 1'b0; flush_tgt = '0;
        discard = 1'b0; exp_pc = 32'h60; exp_addr = 32'h60;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_imem_read", {31'd0, imem_read}, 32'd0);
        check("rst_imem_addr", imem_address, 32'h60);
        @(negedge clk);
        rst = 1'b0;

        // Streaming fetch from reset with one-cycle response latency.
        rdy = 1'b1; mem_en = 1'b1;
        cycle();
        check("first_resp", {31'd0, imem_resp}, 32'd1);
        check("first_addr", imem_address, 32'h60);
        cycle();
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        check("latency_pc", out_pc, 32'h60);
        repeat (6) cycle();

        // Back-pressure fills the FIFO, then fetch stalls until drained.
        rdy = 1'b0;
        repeat (12) cycle();
        check("bp_read_idle", {31'd0, imem_read}, 32'd0);
        check("bp_entries", q.size(), 32'd4);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        rdy = 1'b1;
        repeat (8) cycle();

        // Redirect vectors.
        for (int i = 0; i < 4; i++) begin
            rdy = 1'b1; mem_en = 1'b1;
            repeat (fv[i].pre) cycle();
            old_addr  = exp_addr;
            mem_en    = fv[i].with_resp;
            flush_req = 1'b1;
            flush_tgt = fv[i].fpc;
            cycle();
            @(posedge clk); #1;
            check("flush_empties", {31'd0, out_valid}, 32'd0);
            check("flush_addr", imem_address, fv[i].with_resp ? fv[i].exp_first : old_addr);
            if (!fv[i].with_resp) begin
                repeat (2) cycle();
                check("discard_read", {31'd0, imem_read}, 32'd1);
                check("discard_addr_hold", imem_address, old_addr);
            end
            mem_en = 1'b1;
            wait_valid("redirect", fv[i].exp_first);
            repeat (3) cycle();
        end

        // Reset asserted while a request is outstanding.
        rdy = 1'b0; mem_en = 1'b1;
        repeat (2) cycle();
        mem_en = 1'b0;
        cycle();
        #2 rst = 1'b1;
        #1;
        check("async_rst_read", {31'd0, imem_read}, 32'd0);
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_addr", imem_address, 32'h60);
        q.delete(); exp_pc = 32'h60; exp_addr = 32'h60; discard = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rdy = 1'b1; mem_en = 1'b1;
        wait_valid("restart", 32'h60);
        repeat (6) cycle();

        mem_en = 1'b0;
        repeat (8) cycle();
        check("drain_sb_empty", q.size(), 32'd0);
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running required finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
